// File: rtl/event_capture_pkg.sv
// Shared types and constants for the event capture array.
// Holds edge-select encodings, mode constants and the trigger helper.
package event_capture_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_sel_e;

    localparam logic MODE_L2P = 1'b0;
    localparam logic MODE_P2L = 1'b1;

    function automatic logic edge_trig(
        input edge_sel_e sel,
        input logic      pe,
        input logic      ne
    );
        logic t;
        t = 1'b0;
        case (sel)
            EDGE_NONE: t = 1'b0;
            EDGE_RISE: t = pe;
            EDGE_FALL: t = ne;
            EDGE_BOTH: t = pe | ne;
            default:   t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/event_capture_ch.sv
// One event channel: synchroniser, edge detect, pulse stretcher,
// sticky flag and (with EVT_CNT_EN defined) a saturating event counter.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   d_in                  asynchronous event input
//   mode                  0 = level->pulse, 1 = pulse->level
//   edge_sel              trigger select (none/rise/fall/both)
//   stretch_len           pulse length, sampled at trigger load
//   clear                 sticky flag clear
//   cnt_clr               counter clear (ignored without EVT_CNT_EN)
//   pos_edge/neg_edge/any_edge  raw one-cycle strobes
//   pulse_out, level_flag  stretched pulse / sticky flag
//   evt_cnt               event count (0 without EVT_CNT_EN)
module event_capture_ch
    import event_capture_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH_W   = 4,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 d_in,
    input  logic                 mode,
    input  logic [1:0]           edge_sel,
    input  logic [STRETCH_W-1:0] stretch_len,
    input  logic                 clear,
    input  logic                 cnt_clr,
    output logic                 pos_edge,
    output logic                 neg_edge,
    output logic                 any_edge,
    output logic                 pulse_out,
    output logic                 level_flag,
    output logic [CNT_W-1:0]     evt_cnt
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   d_s;
    logic                   d_q;
    logic                   mode_q;
    logic                   trig;
    logic [STRETCH_W-1:0]   str_q;
    logic [STRETCH_W-1:0]   str_d;
    logic                   flag_q;
    logic                   flag_d;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
    assign d_s    = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            d_q    <= 1'b0;
            mode_q <= MODE_L2P;
            str_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            d_q    <= d_s;
            mode_q <= mode;
            str_q  <= str_d;
            flag_q <= flag_d;
        end
    end

    assign pos_edge = d_s & ~d_q;
    assign neg_edge = ~d_s & d_q;
    assign any_edge = pos_edge | neg_edge;
    assign trig     = edge_trig(edge_sel_e'(edge_sel), pos_edge, neg_edge);

    // A pending mode change wipes the output state of both modes; edge
    // history lives in the synchroniser and is left alone.
    always_comb begin
        str_d  = str_q;
        flag_d = flag_q;
        if (str_q != '0) begin
            str_d = str_q - STRETCH_W'(1);
        end
        if (mode_q != mode) begin
            str_d  = '0;
            flag_d = 1'b0;
        end else if (mode_q == MODE_L2P) begin
            flag_d = 1'b0;
            if (trig) begin
                str_d = (stretch_len == '0) ? STRETCH_W'(1) : stretch_len;
            end
        end else begin
            str_d = '0;
            // Set beats clear so a simultaneous event is not lost.
            if (trig) begin
                flag_d = 1'b1;
            end else if (clear) begin
                flag_d = 1'b0;
            end
        end
    end

    assign pulse_out  = (str_q != '0);
    assign level_flag = flag_q;

`ifdef EVT_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = trig ? CNT_W'(1) : '0;
        end else if (trig && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign evt_cnt = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign evt_cnt        = '0;
`endif

endmodule

// File: rtl/event_capture_array.sv
// Multi-channel level/pulse event converter with aggregated interrupt.
// Optional counters are built when the EVT_CNT_EN macro is defined.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   d_in[CH]            asynchronous event inputs
//   mode[CH]            per channel 0 = level->pulse, 1 = pulse->level
//   edge_sel[2*CH]      per channel trigger select, 2 bits each
//   stretch_len         global pulse length
//   clear[CH]           per channel sticky flag clear
//   cnt_clr             global counter clear
//   pos_edge/neg_edge/any_edge[CH]  raw edge strobes
//   pulse_out[CH], level_flag[CH]   converted outputs
//   irq                 registered OR of level_flag
//   evt_cnt[CH*CNT_W]   channel n at [n*CNT_W +: CNT_W]
module event_capture_array
    import event_capture_pkg::*;
#(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH_W   = 4,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH-1:0]         d_in,
    input  logic [CH-1:0]         mode,
    input  logic [2*CH-1:0]       edge_sel,
    input  logic [STRETCH_W-1:0]  stretch_len,
    input  logic [CH-1:0]         clear,
    input  logic                  cnt_clr,
    output logic [CH-1:0]         pos_edge,
    output logic [CH-1:0]         neg_edge,
    output logic [CH-1:0]         any_edge,
    output logic [CH-1:0]         pulse_out,
    output logic [CH-1:0]         level_flag,
    output logic                  irq,
    output logic [CH*CNT_W-1:0]   evt_cnt
);

    logic irq_q;
    logic irq_d;

    for (genvar n = 0; n < CH; n++) begin : g_ch
        event_capture_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .STRETCH_W   (STRETCH_W),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .d_in        (d_in[n]),
            .mode        (mode[n]),
            .edge_sel    (edge_sel[2*n +: 2]),
            .stretch_len (stretch_len),
            .clear       (clear[n]),
            .cnt_clr     (cnt_clr),
            .pos_edge    (pos_edge[n]),
            .neg_edge    (neg_edge[n]),
            .any_edge    (any_edge[n]),
            .pulse_out   (pulse_out[n]),
            .level_flag  (level_flag[n]),
            .evt_cnt     (evt_cnt[n*CNT_W +: CNT_W])
        );
    end

    assign irq_d = |level_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_event_capture_array.sv
// Randomised and directed bench for event_capture_array.
// Reference model tracks input history, trigger times and flag state.
module tb_event_capture_array;
    import event_capture_pkg::*;

    localparam int CH   = 4;
    localparam int SS   = 2;
    localparam int SW   = 4;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CH-1:0]     d_in;
    logic [CH-1:0]     mode;
    logic [2*CH-1:0]   edge_sel;
    logic [SW-1:0]     stretch_len;
    logic [CH-1:0]     clear;
    logic              cnt_clr;
    logic [CH-1:0]     pos_edge;
    logic [CH-1:0]     neg_edge;
    logic [CH-1:0]     any_edge;
    logic [CH-1:0]     pulse_out;
    logic [CH-1:0]     level_flag;
    logic              irq;
    logic [CH*CW-1:0]  evt_cnt;

    event_capture_array #(
        .CH(CH), .SYNC_STAGES(SS), .STRETCH_W(SW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .mode(mode),
        .edge_sel(edge_sel), .stretch_len(stretch_len),
        .clear(clear), .cnt_clr(cnt_clr),
        .pos_edge(pos_edge), .neg_edge(neg_edge), .any_edge(any_edge),
        .pulse_out(pulse_out), .level_flag(level_flag), .irq(irq),
        .evt_cnt(evt_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [CH-1:0] hist[$];
    int            t;
    int            ptime[CH];
    int            plen[CH];
    logic [CH-1:0] mflag;
    logic          mirq;
    int            mcnt[CH];
    logic [CH-1:0] mmode;

    task automatic m_reset();
        hist.delete();
        for (int i = 0; i <= SS; i++) hist.push_back('0);
        for (int n = 0; n < CH; n++) begin
            ptime[n] = 0;
            plen[n]  = 0;
            mcnt[n]  = 0;
        end
        mflag = '0;
        mirq  = 1'b0;
        mmode = '0;
    endtask

    // Oldest entries are what the synchroniser currently presents.
    function automatic logic [CH-1:0] m_ds();
        return hist[hist.size()-SS];
    endfunction

    function automatic logic [CH-1:0] m_dq();
        return hist[hist.size()-SS-1];
    endfunction

    task automatic compare_all();
        logic [CH-1:0]    pe, ne, pu;
        logic [CH*CW-1:0] ev;
        pe = m_ds() & ~m_dq();
        ne = ~m_ds() & m_dq();
        pu = '0;
        ev = '0;
        for (int n = 0; n < CH; n++) begin
            pu[n] = ((t - ptime[n]) >= 1) && ((t - ptime[n]) <= plen[n]);
`ifdef EVT_CNT_EN
            ev[n*CW +: CW] = CW'(mcnt[n]);
`endif
        end
        check("pos_edge", 64'(pos_edge), 64'(pe));
        check("neg_edge", 64'(neg_edge), 64'(ne));
        check("any_edge", 64'(any_edge), 64'(pe | ne));
        check("pulse_out", 64'(pulse_out), 64'(pu));
        check("level_flag", 64'(level_flag), 64'(mflag));
        check("irq", 64'(irq), 64'(mirq));
        check("evt_cnt", 64'(evt_cnt), 64'(ev));
    endtask

    // Advance one clock: update model with the currently driven
    // inputs, take the edge, then compare just after it.
    task automatic step();
        logic [CH-1:0] pe, ne, trig;
        pe = m_ds() & ~m_dq();
        ne = ~m_ds() & m_dq();
        for (int n = 0; n < CH; n++)
            trig[n] = (pe[n] & edge_sel[2*n]) | (ne[n] & edge_sel[2*n+1]);
        mirq = |mflag;
        for (int n = 0; n < CH; n++) begin
            if (mode[n] != mmode[n]) begin
                plen[n]  = 0;
                mflag[n] = 1'b0;
            end else if (mmode[n] == MODE_L2P) begin
                if (trig[n]) begin
                    ptime[n] = t;
                    plen[n]  = (stretch_len == 0) ? 1 : int'(stretch_len);
                end
            end else begin
                if (trig[n]) mflag[n] = 1'b1;
                else if (clear[n]) mflag[n] = 1'b0;
            end
            if (cnt_clr) mcnt[n] = trig[n] ? 1 : 0;
            else if (trig[n] && mcnt[n] < CMAX) mcnt[n]++;
        end
        mmode = mode;
        hist.push_back(d_in);
        void'(hist.pop_front());
        t++;
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_pos", 64'(pos_edge), 64'd0);
        check("rst_pulse", 64'(pulse_out), 64'd0);
        check("rst_flag", 64'(level_flag), 64'd0);
        check("rst_irq", 64'(irq), 64'd0);
        check("rst_cnt", 64'(evt_cnt), 64'd0);
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic int cnt_exp(input int v);
`ifdef EVT_CNT_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    int first_hi, last_hi, n_hi, pos_at;

    initial begin
        rst_n       = 1'b0;
        d_in        = '0;
        mode        = '0;
        edge_sel    = '0;
        stretch_len = SW'(3);
        clear       = '0;
        cnt_clr     = 1'b0;
        t           = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_flag", 64'(level_flag), 64'd0);
        check("reset_cnt", 64'(evt_cnt), 64'd0);
        rst_n = 1'b1;

        // Ch0 rising edge, mode 0
        edge_sel[1:0] = EDGE_RISE;
        d_in[0] = 1'b1;
        n_hi = 0;
        pos_at = -1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (pos_edge[0] && pos_at < 0) pos_at = i;
            if (pulse_out[0]) n_hi++;
        end
        check("ch0_pos_lat", 64'(pos_at), 64'd2);
        check("ch0_pulse_w", 64'(n_hi), 64'd3);
        check("ch0_cnt", 64'(evt_cnt[0 +: CW]), 64'(cnt_exp(1)));

        // Ch1 both edges two cycles apart -> one merged pulse
        edge_sel[3:2] = EDGE_BOTH;
        d_in[1] = 1'b1;
        step();
        step();
        d_in[1] = 1'b0;
        n_hi = 0;
        first_hi = -1;
        last_hi = -1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (pulse_out[1]) begin
                n_hi++;
                if (first_hi < 0) first_hi = i;
                last_hi = i;
            end
        end
        check("ch1_pulse_w", 64'(n_hi), 64'd5);
        check("ch1_no_gap", 64'(last_hi - first_hi + 1), 64'd5);
        check("ch1_cnt", 64'(evt_cnt[CW +: CW]), 64'(cnt_exp(2)));

        // Ch2 sticky flag and irq
        mode[2] = MODE_P2L;
        edge_sel[5:4] = EDGE_RISE;
        step();
        step();
        d_in[2] = 1'b1;
        repeat (4) step();
        check("ch2_flag", 64'(level_flag[2]), 64'd1);
        check("ch2_irq", 64'(irq), 64'd1);
        clear[2] = 1'b1;
        step();
        clear[2] = 1'b0;
        check("ch2_clr_flag", 64'(level_flag[2]), 64'd0);
        step();
        check("ch2_clr_irq", 64'(irq), 64'd0);

        // Ch3 clear in the trigger cycle: set wins
        mode[3] = MODE_P2L;
        edge_sel[7:6] = EDGE_RISE;
        step();
        step();
        d_in[3] = 1'b1;
        step();
        step();
        check("ch3_trig_now", 64'(pos_edge[3]), 64'd1);
        clear[3] = 1'b1;
        step();
        clear[3] = 1'b0;
        check("ch3_set_wins", 64'(level_flag[3]), 64'd1);
        clear[3] = 1'b1;
        step();
        clear[3] = 1'b0;
        step();

        // stretch_len = 0 gives a one-cycle pulse
        stretch_len = '0;
        d_in[0] = 1'b0;
        edge_sel[1:0] = EDGE_FALL;
        n_hi = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (pulse_out[0]) n_hi++;
        end
        check("len0_pulse_w", 64'(n_hi), 64'd1);

        // Saturation on ch0
        edge_sel[1:0] = EDGE_BOTH;
        for (int i = 0; i < 260; i++) begin
            d_in[0] = ~d_in[0];
            step();
        end
        repeat (3) step();
        check("ch0_sat", 64'(evt_cnt[0 +: CW]), 64'(cnt_exp(CMAX)));
        d_in[0] = ~d_in[0];
        step();
        step();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("ch0_clr_trig", 64'(evt_cnt[0 +: CW]), 64'(cnt_exp(1)));

        // Reset during active pulse and set flag
        stretch_len = SW'(15);
        d_in[2] = 1'b0;
        step();
        step();
        d_in[2] = 1'b1;
        d_in[0] = ~d_in[0];
        repeat (4) step();
        check("pre_rst_pulse", 64'(pulse_out[0]), 64'd1);
        check("pre_rst_flag", 64'(level_flag[2]), 64'd1);
        do_reset();

        // Mode toggle clears flag on ch2
        d_in = '0;
        stretch_len = SW'(3);
        repeat (4) step();
        d_in[2] = 1'b1;
        repeat (4) step();
        check("ch2_flag2", 64'(level_flag[2]), 64'd1);
        mode[2] = MODE_L2P;
        step();
        step();
        check("mode_chg_flag", 64'(level_flag[2]), 64'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            d_in        = CH'($urandom);
            clear       = CH'($urandom) & CH'($urandom);
            cnt_clr     = ($urandom_range(0, 31) == 0);
            stretch_len = SW'($urandom);
            if ($urandom_range(0, 15) == 0) mode[$urandom_range(0, CH-1)] ^= 1'b1;
            if ($urandom_range(0, 31) == 0) edge_sel = (2*CH)'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
